// File: rtl/csr_counter_bank.sv
// csr_counter_bank
//   Machine counter / event CSR bank: mcycle, minstret, NUM_HPM programmable
//   hardware performance counters with event selection, mcountinhibit,
//   debug stop-count, and sticky overflow flags feeding a level interrupt.
//
// Ports
//   clk             core clock
//   rst_n           asynchronous active-low reset
//   csr_addr        CSR address of the current access
//   csr_wdata       final write value (rw/set/clear already resolved)
//   csr_we          commit the write at the next rising clk
//   csr_rdata       combinational read data, 0 when csr_hit is low
//   csr_hit         csr_addr lies in this bank's address map
//   retire          one instruction retired this cycle
//   events          per-cycle event pulses, selected by mhpmeventN[7:0]
//   debug_stopcount freeze every counter while set
//   ovf_irq         OR of all overflow flags not masked by MINH
module csr_counter_bank #(
    parameter int NUM_HPM   = 4,
    parameter int CNT_WIDTH = 64,
    parameter int EVT_WIDTH = 8,
    parameter int XLEN      = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [11:0]          csr_addr,
    input  logic [XLEN-1:0]      csr_wdata,
    input  logic                 csr_we,
    output logic [XLEN-1:0]      csr_rdata,
    output logic                 csr_hit,
    input  logic                 retire,
    input  logic [EVT_WIDTH-1:0] events,
    input  logic                 debug_stopcount,
    output logic                 ovf_irq
);

    // Arrays keep at least one element so NUM_HPM = 0 still elaborates.
    localparam int NH = (NUM_HPM > 0) ? NUM_HPM : 1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    // ------------------------------------------------------------------
    // Address decode. Index 1 (time) and event indices 1/2 are not ours.
    // ------------------------------------------------------------------
    logic [4:0]  idx;
    logic        in_lo;
    logic        in_hi;
    logic        in_evt;
    logic        wr_lo;
    logic        wr_hi;
    logic        wr_evt;
    logic [31:0] wd;

    assign idx     = csr_addr[4:0];
    assign in_lo   = (csr_addr[11:5] == 7'b1011_000) && (idx != 5'd1);
    assign in_hi   = (csr_addr[11:5] == 7'b1011_100) && (idx != 5'd1);
    assign in_evt  = (csr_addr[11:5] == 7'b0011_001) && (idx != 5'd1) && (idx != 5'd2);
    assign csr_hit = in_lo | in_hi | in_evt;

    assign wr_lo  = csr_we & in_lo;
    assign wr_hi  = csr_we & in_hi;
    assign wr_evt = csr_we & in_evt;
    assign wd     = csr_wdata[31:0];

    // A software write to either half takes priority over the increment.
    function automatic logic [CNT_WIDTH-1:0] cnt_next(
        input logic [CNT_WIDTH-1:0] cur,
        input logic                 w_lo,
        input logic                 w_hi,
        input logic                 inc,
        input logic [31:0]          data
    );
        logic [CNT_WIDTH-1:0] r;
        r = cur;
        if (w_lo)
            r[31:0] = data;
        else if (w_hi)
            r[CNT_WIDTH-1:32] = data[CNT_WIDTH-33:0];
        else if (inc)
            r = cur + CNT_ONE;
        return r;
    endfunction

    // ------------------------------------------------------------------
    // mcycle, minstret and their inhibit bits
    // ------------------------------------------------------------------
    logic [CNT_WIDTH-1:0] cyc_q;
    logic [CNT_WIDTH-1:0] ins_q;
    logic                 inh_cy_q;
    logic                 inh_ir_q;
    logic                 run;

    assign run = ~debug_stopcount;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc_q    <= '0;
            ins_q    <= '0;
            inh_cy_q <= 1'b0;
            inh_ir_q <= 1'b0;
        end else begin
            cyc_q <= cnt_next(cyc_q, wr_lo && (idx == 5'd0), wr_hi && (idx == 5'd0),
                              run && !inh_cy_q, wd);
            ins_q <= cnt_next(ins_q, wr_lo && (idx == 5'd2), wr_hi && (idx == 5'd2),
                              run && !inh_ir_q && retire, wd);
            if (wr_evt && (idx == 5'd0)) begin
                inh_cy_q <= wd[0];
                inh_ir_q <= wd[2];
            end
        end
    end

    // ------------------------------------------------------------------
    // Programmable counters mhpmcounter3 .. 3+NUM_HPM-1
    // ------------------------------------------------------------------
    logic [CNT_WIDTH-1:0] hpm_cnt [NH];
    logic [7:0]           hpm_sel [NH];
    logic [NH-1:0]        hpm_of;
    logic [NH-1:0]        hpm_minh;
    logic [NH-1:0]        hpm_inh;

    if (NUM_HPM == 0) begin : g_no_hpm
        assign hpm_cnt[0] = '0;
        assign hpm_sel[0] = '0;
        assign hpm_of     = '0;
        assign hpm_minh   = '0;
        assign hpm_inh    = '0;
    end

    for (genvar k = 0; k < NUM_HPM; k++) begin : g_hpm
        localparam logic [4:0] IDX = 5'(k + 3);

        logic [CNT_WIDTH-1:0] cnt_q;
        logic [7:0]           sel_q;
        logic                 of_q;
        logic                 minh_q;
        logic                 inh_q;
        logic                 src;
        logic                 inc;
        logic                 w_lo;
        logic                 w_hi;
        logic                 w_ev;
        logic                 wrap;

        // Selector 0 or beyond EVT_WIDTH matches no event and never counts.
        always_comb begin
            src = 1'b0;
            for (int e = 0; e < EVT_WIDTH; e++)
                if (sel_q == 8'(e + 1))
                    src = events[e];
        end

        assign w_lo = wr_lo && (idx == IDX);
        assign w_hi = wr_hi && (idx == IDX);
        assign w_ev = wr_evt && (idx == IDX);
        assign inc  = run && !inh_q && src;
        assign wrap = inc && !w_lo && !w_hi && (&cnt_q);

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt_q  <= '0;
                sel_q  <= '0;
                of_q   <= 1'b0;
                minh_q <= 1'b0;
                inh_q  <= 1'b0;
            end else begin
                cnt_q <= cnt_next(cnt_q, w_lo, w_hi, inc, wd);
                if (wr_evt && (idx == 5'd0))
                    inh_q <= wd[3+k];
                // A wrap on the same edge as a software write still sets OF.
                if (w_ev) begin
                    sel_q  <= wd[7:0];
                    minh_q <= wd[30];
                    of_q   <= wd[31] | wrap;
                end else begin
                    of_q <= of_q | wrap;
                end
            end
        end

        assign hpm_cnt[k]  = cnt_q;
        assign hpm_sel[k]  = sel_q;
        assign hpm_of[k]   = of_q;
        assign hpm_minh[k] = minh_q;
        assign hpm_inh[k]  = inh_q;
    end

    assign ovf_irq = |(hpm_of & ~hpm_minh);

    // ------------------------------------------------------------------
    // Read mux. Counters are zero-extended to 64 bits so high halves read
    // 0 above CNT_WIDTH.
    // ------------------------------------------------------------------
    logic [63:0] cnt_sel;
    logic [31:0] rd;

    always_comb begin
        cnt_sel = '0;
        rd      = '0;
        if (idx == 5'd0)
            cnt_sel = 64'(cyc_q);
        if (idx == 5'd2)
            cnt_sel = 64'(ins_q);
        for (int k = 0; k < NUM_HPM; k++)
            if (idx == 5'(k + 3))
                cnt_sel = 64'(hpm_cnt[k]);

        if (in_lo) begin
            rd = cnt_sel[31:0];
        end else if (in_hi) begin
            rd = cnt_sel[63:32];
        end else if (in_evt) begin
            if (idx == 5'd0) begin
                rd[0] = inh_cy_q;
                rd[2] = inh_ir_q;
                for (int k = 0; k < NUM_HPM; k++)
                    rd[3+k] = hpm_inh[k];
            end
            for (int k = 0; k < NUM_HPM; k++)
                if (idx == 5'(k + 3))
                    rd = {hpm_of[k], hpm_minh[k], 22'd0, hpm_sel[k]};
        end
    end

    assign csr_rdata = XLEN'(rd);

endmodule
